// File: rtl/axil_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite register file.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Index width is kept at least 1 so a single-register file still has a legal slice.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder with NUM_REGS byte-writable 32-bit registers, independent AW/W
// acceptance, SLVERR on out-of-range addresses and per-register write pulses.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W = idx_width(NUM_REGS);
  localparam logic [AW:0] RANGE_LIMIT = (AW+1)'(NUM_REGS * 4);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < RANGE_LIMIT);
  endfunction

  wr_state_t             wr_state_q, wr_state_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [AW-1:0]         aw_addr_q, aw_addr_d;
  logic [DW-1:0]         w_data_q, w_data_d;
  logic [DW/8-1:0]       w_strb_q, w_strb_d;
  logic [DW-1:0]         regs_q [NUM_REGS];
  logic [DW-1:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [AW-1:0]         commit_addr_s;
  logic [DW-1:0]         commit_data_s;
  logic [DW/8-1:0]       commit_strb_s;
  logic [IDX_W-1:0]      commit_idx_s, ar_idx_s;
  logic                  unused_s;

  assign aw_hs_s      = S_AXI_AWVALID & awready_q;
  assign w_hs_s       = S_AXI_WVALID & wready_q;
  assign ar_hs_s      = S_AXI_ARVALID & arready_q;
  assign commit_idx_s = commit_addr_s[2 +: IDX_W];
  assign ar_idx_s     = S_AXI_ARADDR[2 +: IDX_W];
  assign unused_s     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], commit_addr_s[1:0]};

  // Write FSM: collect AW and W in either order, commit once both are present.
  always_comb begin
    wr_state_d    = wr_state_q;
    aw_addr_d     = aw_addr_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    commit_s      = 1'b0;
    commit_addr_s = aw_addr_q;
    commit_data_s = w_data_q;
    commit_strb_s = w_strb_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          commit_s      = 1'b1;
          commit_addr_s = S_AXI_AWADDR;
          commit_data_s = S_AXI_WDATA;
          commit_strb_s = S_AXI_WSTRB;
        end else if (aw_hs_s) begin
          aw_addr_d  = S_AXI_AWADDR;
          wr_state_d = W_HAVE_A;
        end else if (w_hs_s) begin
          w_data_d   = S_AXI_WDATA;
          w_strb_d   = S_AXI_WSTRB;
          wr_state_d = W_HAVE_D;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_HAVE_A: begin
        if (w_hs_s) begin
          commit_s      = 1'b1;
          commit_data_s = S_AXI_WDATA;
          commit_strb_s = S_AXI_WSTRB;
        end else begin
          wr_state_d = W_HAVE_A;
        end
      end
      W_HAVE_D: begin
        if (aw_hs_s) begin
          commit_s      = 1'b1;
          commit_addr_s = S_AXI_AWADDR;
        end else begin
          wr_state_d = W_HAVE_D;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        bvalid_d   = 1'b0;
      end
    endcase
    if (commit_s) begin
      wr_state_d = W_RESP;
      bvalid_d   = 1'b1;
      bresp_d    = addr_ok(commit_addr_s) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_d = bresp_q;
    end
    // Readies are registered copies of what the next state will accept.
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_D);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_A);
  end

  // Register-array update and write pulse on an in-range commit.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit_s && addr_ok(commit_addr_s)) begin
      regs_d[commit_idx_s]  = merge_strb(regs_q[commit_idx_s], commit_data_s, commit_strb_s);
      pulse_d[commit_idx_s] = 1'b1;
    end else begin
      pulse_d = '0;
    end
  end

  // Read FSM: sample the addressed register on AR, hold R until accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_DATA;
          rvalid_d   = 1'b1;
          if (addr_ok(S_AXI_ARADDR)) begin
            rdata_d = regs_q[ar_idx_s];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = {DW{1'b0}};
            rresp_d = RESP_SLVERR;
          end
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        rvalid_d   = 1'b0;
      end
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  // Write-channel state and registered write-side outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_addr_q  <= {AW{1'b0}};
      w_data_q   <= {DW{1'b0}};
      w_strb_q   <= {(DW/8){1'b0}};
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  // Register storage and write pulses.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  // Read-channel state and registered read-side outputs.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= {DW{1'b0}};
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[DW*g +: DW] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile: a transaction-level register model is
// checked against reg_q / reg_wr_pulse every cycle, and each AXI response is checked in-line.
module tb_axil_slave_regfile;

  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [2:0]      awprot = 3'd0, arprot = 3'd0;
  logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]     wdata = 32'd0;
  logic [3:0]      wstrb = 4'd0;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]   reg_wr_pulse;

  axil_slave_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  logic [31:0]   model_regs [NR];
  logic [NR-1:0] pulse_val = '0;
  int            pulse_at = -1;
  int            cyc = 0;
  int            n_vec = 0, n_err = 0;
  bit            mon_en = 1'b0;
  logic [31:0]   got_d;
  logic [1:0]    got_r;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
    return (int'(a) < NR * 4) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    return (int'(a) < NR * 4) ? model_regs[int'(a) / 4] : 32'd0;
  endfunction

  // Apply a completed write to the model; called just after the commit edge.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (int'(a) < NR * 4) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_regs[int'(a) / 4][8*b +: 8] = d[8*b +: 8];
      end
      pulse_val = 4'b0001 << (int'(a) / 4);
      pulse_at  = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("reg_q", reg_q, model_flat());
      chk("reg_wr_pulse", 128'(reg_wr_pulse), (cyc == pulse_at) ? 128'(pulse_val) : 128'd0);
    end
  end

  function automatic logic sig(input int ch);
    case (ch)
      0:       return awready;
      1:       return wready;
      2:       return arready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int ch, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!sig(ch) && t < 50);
    if (!sig(ch)) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: got 0 expected 1 within 50 cycles", name);
    end
  endtask

  task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold,
                           output logic [1:0] resp);
    logic [1:0] exp_resp;
    exp_resp = model_resp(a);
    @(posedge clk); #1;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        wait_hi(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_hi(1, "wready");
        @(posedge clk); #1;
        wvalid = 1'b0;
        if (aw_dly > w_dly) begin
          @(negedge clk);
          chk("wready_after_w", 128'(wready), 128'd0);
          chk("awready_have_d", 128'(awready), 128'd1);
        end
      end
    join
    model_write(a, d, s);
    @(negedge clk);
    chk("bvalid_rise", 128'(bvalid), 128'd1);
    chk("bresp", 128'(bresp), 128'(exp_resp));
    resp = bresp;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 128'(bvalid), 128'd1);
      chk("bresp_hold", 128'(bresp), 128'(exp_resp));
      chk("awready_in_resp", 128'(awready), 128'd0);
      chk("wready_in_resp", 128'(wready), 128'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("bvalid_drop", 128'(bvalid), 128'd0);
    chk("awready_back", 128'(awready), 128'd1);
    chk("wready_back", 128'(wready), 128'd1);
  endtask

  task automatic read_txn(input logic [AW-1:0] a, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    wait_hi(2, "arready");
    exp_d = model_read(a);
    exp_r = model_resp(a);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_rise", 128'(rvalid), 128'd1);
    chk("rdata", 128'(rdata), 128'(exp_d));
    chk("rresp", 128'(rresp), 128'(exp_r));
    chk("arready_busy", 128'(arready), 128'd0);
    data = rdata;
    resp = rresp;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 128'(rvalid), 128'd1);
      chk("rdata_hold", 128'(rdata), 128'(exp_d));
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    chk("rvalid_drop", 128'(rvalid), 128'd0);
    chk("arready_back", 128'(arready), 128'd1);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model_regs[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 128'(awready), 128'd0);
    chk("rst_wready", 128'(wready), 128'd0);
    chk("rst_arready", 128'(arready), 128'd0);
    chk("rst_bvalid", 128'(bvalid), 128'd0);
    chk("rst_rvalid", 128'(rvalid), 128'd0);
    chk("rst_resp", 128'({bresp, rresp}), 128'd0);
    chk("rst_rdata", 128'(rdata), 128'd0);
    chk("rst_reg_q", reg_q, 128'd0);
    chk("rst_pulse", 128'(reg_wr_pulse), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 128'({awready, wready, arready}), 128'd0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_after_edge", 128'({awready, wready, arready}), 128'h7);

    // Sequential writes then reads
    for (int i = 0; i < NR; i++) begin
      write_txn(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, got_r);
      chk("t1_bresp_lit", 128'(got_r), 128'd0);
    end
    for (int i = 0; i < NR; i++) begin
      read_txn(AW'(4 * i), i, got_d, got_r);
      chk("t1_rdata_lit", 128'(got_d), 128'(i + 1));
    end
    chk("t1_reg_q_lit", reg_q, 128'h00000004_00000003_00000002_00000001);

    // Byte strobes
    write_txn(5'h04, 32'h11223344, 4'hF, 0, 0, 0, got_r);
    write_txn(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, got_r);
    read_txn(5'h04, 0, got_d, got_r);
    chk("t2_rdata_lit", 128'(got_d), 128'h11BB33DD);

    // W leads AW by 3 cycles, then AW leads W
    write_txn(5'h08, 32'hCAFE0003, 4'hF, 3, 0, 0, got_r);
    read_txn(5'h08, 0, got_d, got_r);
    chk("t3_rdata_lit", 128'(got_d), 128'hCAFE0003);
    write_txn(5'h0C, 32'h0BAD0004, 4'hF, 0, 2, 0, got_r);
    write_txn(5'h0E, 32'h00000004, 4'hF, 0, 0, 0, got_r);

    // Out of range
    write_txn(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, got_r);
    chk("t4_bresp_lit", 128'(got_r), 128'h2);
    read_txn(5'h14, 0, got_d, got_r);
    chk("t4_rdata_lit", 128'(got_d), 128'd0);
    chk("t4_rresp_lit", 128'(got_r), 128'h2);
    chk("t4_reg_q_lit", reg_q, 128'h00000004_CAFE0003_11BB33DD_00000001);

    // WSTRB = 0 still pulses, then back-pressured B
    write_txn(5'h00, 32'hFFFFFFFF, 4'h0, 0, 0, 0, got_r);
    write_txn(5'h0D, 32'h00000055, 4'h1, 0, 0, 10, got_r);
    chk("t5_reg3_lit", 128'(reg_q[127:96]), 128'h00000055);

    // Reset in W_HAVE_A with RVALID pending
    @(posedge clk); #1;
    awaddr = 5'h00; awvalid = 1'b1;
    wait_hi(0, "awready_t6");
    @(posedge clk); #1;
    awvalid = 1'b0;
    araddr = 5'h04; arvalid = 1'b1;
    wait_hi(2, "arready_t6");
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_pending", 128'(rvalid), 128'd1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) model_regs[i] = 32'd0;
    #1;
    chk("t6_rvalid_async", 128'(rvalid), 128'd0);
    chk("t6_bvalid_async", 128'(bvalid), 128'd0);
    chk("t6_reg_q_async", reg_q, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_bvalid_after", 128'(bvalid), 128'd0);
    chk("t6_ready_after", 128'({awready, wready, arready}), 128'h7);
    read_txn(5'h00, 0, got_d, got_r);
    chk("t6_rdata_lit", 128'(got_d), 128'd0);
    write_txn(5'h08, 32'h12345678, 4'hF, 0, 0, 0, got_r);
    chk("t6_reg2_lit", 128'(reg_q[95:64]), 128'h12345678);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
